row_buffer_ctrl: RTL and testbench
==================================

// Module: row_buffer_ctrl
// PURPOSE
//  Upstream sequencer for the row-buffer memory module (MM). Accepts a raster pixel stream and
//  drives MM's write and read ports. Rows are stored interleaved: address = col*RB_COUNT + slot.
//  Emits one KERNEL_SIZE-tall pixel column per accepted pixel, ordered oldest row first, to the
//  window stage.
// PARAMETERS
//  PIXEL_BITS   8    bits per pixel
//  IMAGE_WIDTH  256  pixels per row
//  IMAGE_HEIGHT 256  rows per frame
//  KERNEL_SIZE  9    window height; RB_COUNT = KERNEL_SIZE-1 stored rows
// PORTS
//  clk            in   1                            clock, all logic rising-edge
//  rst            in   1                            reset, asynchronous, active-low
//  s_valid        in   1                            input pixel valid
//  s_ready        out  1                            input pixel accepted when s_valid&&s_ready
//  s_pixel        in   PIXEL_BITS                   raster-order pixel
//  mm_we          out  1                            MM write enable
//  mm_write_data  out  PIXEL_BITS                   MM write data
//  mm_write_addr  out  $clog2(RB_COUNT*IMAGE_WIDTH) MM write address
//  mm_re          out  1                            MM read enable
//  mm_read_addr   out  $clog2(IMAGE_WIDTH)          MM column read address
//  mm_read_data   in   PIXEL_BITS*RB_COUNT          MM read data, lane i = slot i, 1-cycle latency
//  m_valid        out  1                            column valid
//  m_ready        in   1                            downstream accepts column
//  m_column       out  PIXEL_BITS*KERNEL_SIZE       lane 0 = oldest row ... lane RB_COUNT = current pixel
//  m_col_idx      out  $clog2(IMAGE_WIDTH)          column of m_column
//  m_row_idx      out  $clog2(IMAGE_HEIGHT)         row of current pixel
//  m_full         out  1                            1 when m_row_idx >= RB_COUNT (all lanes hold real rows)
// BEHAVIOUR
//  Reset (rst=0, async): col/row counters=0, slot=0, m_valid=0, m_full=0, m_col_idx=0, m_row_idx=0.
//   A run flag is cleared in reset and set on the first clk after release. While run=0:
//   s_ready=0, mm_we=0, mm_re=0. MM contents are not cleared.
//  Handshake
//   - s_ready = run && (!m_valid || m_ready).
//   - accept = s_valid && s_ready.
//  On accept (combinational to MM)
//   - mm_we = mm_re = 1; mm_write_data = s_pixel.
//   - mm_read_addr = col; mm_write_addr = col*RB_COUNT + slot.
//   - MM read-before-write: the same-cycle read returns the old slot content, which is the
//     oldest row.
//  Registered on accept
//   - pix_q, slot_q, m_col_idx, m_row_idx, m_full.
//   - m_valid=1 in the next cycle (latency 1).
//   - m_valid holds until m_valid&&m_ready with no new accept in that cycle.
//   - accept in the same cycle as a drain keeps m_valid=1 (full throughput, 1 pixel/clk).
//  Stall
//   - mm_re=0 while stalled, so MM read_data and m_column stay stable until the handshake.
//  Lane order
//   - lane j (j<RB_COUNT) = mm_read_data slot (slot_q+j) mod RB_COUNT.
//   - lane RB_COUNT = pix_q.
//  Counters
//   - col wraps IMAGE_WIDTH-1 -> 0 and advances row.
//   - slot advances mod RB_COUNT at each row end.
//   - row wraps IMAGE_HEIGHT-1 -> 0; at frame wrap slot is forced to 0.
//   - m_full=0 until RB_COUNT rows of the new frame are stored (stale rows from the prior frame
//     are never flagged full).
//  s_valid low mid-row: no state change, no MM access.
// CONFIGURATION
//  ROWBUF_ZERO_PAD_EN
//   - defined: lane j is forced to 0 when m_row_idx < RB_COUNT-j (row above frame top).
//   - undefined: lanes pass MM content unmodified (stale/undefined above frame top);
//     consumers gate on m_full.
// TESTING  (bench: KERNEL_SIZE=3, IMAGE_WIDTH=4, IMAGE_HEIGHT=4, pixel(r,c)=0x80+16r+c, m_ready=1 unless stated)
//  1. Reset
//   - rst low mid-row -> same-cycle s_ready=0, mm_we=0, m_valid=0.
//   - after release, first accepted pixel -> mm_write_addr=0, mm_read_addr=0.
//  2. Fill rows 0..2
//   - rows 0,1 -> m_full=0.
//   - (2,1) -> m_column lanes {0x81,0x91,0xA1}, m_full=1, m_col_idx=1, m_row_idx=2.
//  3. Slot rotation
//   - (3,2) -> mm_write_addr=5, mm_read_addr=2.
//   - next cycle lanes {0x92,0xA2,0xB2}.
//  4. Backpressure
//   - m_ready=0 for 5 cycles at (2,3) -> m_column constant, s_ready=0, mm_re=0.
//   - after release, full stream resumes with no pixel dropped or duplicated.
//  5. Frame wrap
//   - after (3,3), pixel (0,0) of frame 2 -> m_row_idx=0, m_full=0, mm_write_addr=0.
//  6. ROWBUF_ZERO_PAD_EN defined, (1,0)
//   - lanes {0x00,0x80,0x90}.
//   - undefined: lane 1=0x80, lane 2=0x90, lane 0 unchecked.

Source files
------------

// File: rtl/row_buffer_ctrl.sv
// Row-buffer sequencer: streams raster pixels into the interleaved row memory and emits
// one KERNEL_SIZE-tall column per pixel. Define ROWBUF_ZERO_PAD_EN to zero lanes above frame top.
module row_buffer_ctrl #(
    parameter int PIXEL_BITS   = 8,
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256,
    parameter int KERNEL_SIZE  = 9
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              s_valid,
    output logic                                              s_ready,
    input  logic [PIXEL_BITS-1:0]                             s_pixel,
    output logic                                              mm_we,
    output logic [PIXEL_BITS-1:0]                             mm_write_data,
    output logic [$clog2((KERNEL_SIZE-1)*IMAGE_WIDTH)-1:0]    mm_write_addr,
    output logic                                              mm_re,
    output logic [$clog2(IMAGE_WIDTH)-1:0]                    mm_read_addr,
    input  logic [PIXEL_BITS*(KERNEL_SIZE-1)-1:0]             mm_read_data,
    output logic                                              m_valid,
    input  logic                                              m_ready,
    output logic [PIXEL_BITS*KERNEL_SIZE-1:0]                 m_column,
    output logic [$clog2(IMAGE_WIDTH)-1:0]                    m_col_idx,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]                   m_row_idx,
    output logic                                              m_full
);

    localparam int unsigned RB_COUNT  = KERNEL_SIZE - 1;
    localparam int          WA_BITS   = $clog2(RB_COUNT * IMAGE_WIDTH);
    localparam int          COL_BITS  = $clog2(IMAGE_WIDTH);
    localparam int          ROW_BITS  = $clog2(IMAGE_HEIGHT);
    localparam int          SLOT_BITS = (RB_COUNT > 1) ? $clog2(RB_COUNT) : 1;

    localparam logic [COL_BITS-1:0]  COL_LAST  = COL_BITS'(IMAGE_WIDTH - 1);
    localparam logic [ROW_BITS-1:0]  ROW_LAST  = ROW_BITS'(IMAGE_HEIGHT - 1);
    localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(RB_COUNT - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                state;
    state_t                state_next;
    logic                  run;
    logic                  accept;
    logic [COL_BITS-1:0]   col;
    logic [ROW_BITS-1:0]   row;
    logic [SLOT_BITS-1:0]  slot;
    logic [SLOT_BITS-1:0]  slot_q;
    logic [PIXEL_BITS-1:0] pix_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        run = (state == ST_RUN);
    end

    // Stalling drops mm_re so the memory's read register, and thus m_column, holds.
    always_comb begin
        s_ready       = run && (!m_valid || m_ready);
        accept        = s_valid && s_ready;
        mm_we         = accept;
        mm_re         = accept;
        mm_write_data = s_pixel;
        mm_read_addr  = col;
        mm_write_addr = WA_BITS'(col) * WA_BITS'(RB_COUNT) + WA_BITS'(slot);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            slot      <= '0;
            slot_q    <= '0;
            pix_q     <= '0;
            m_valid   <= 1'b0;
            m_full    <= 1'b0;
            m_col_idx <= '0;
            m_row_idx <= '0;
        end else begin
            if (accept) begin
                m_valid   <= 1'b1;
                pix_q     <= s_pixel;
                slot_q    <= slot;
                m_col_idx <= col;
                m_row_idx <= row;
                m_full    <= (32'(row) >= RB_COUNT);
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row  <= '0;
                        slot <= '0;
                    end else begin
                        row  <= row + 1'b1;
                        slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Slot slot_q holds the oldest row, so lanes rotate from there.
    always_comb begin
        int unsigned src;
        src      = 0;
        m_column = '0;
        for (int unsigned j = 0; j < RB_COUNT; j++) begin
            src = 32'(slot_q) + j;
            if (src >= RB_COUNT) src = src - RB_COUNT;
            m_column[j*PIXEL_BITS +: PIXEL_BITS] = mm_read_data[src*PIXEL_BITS +: PIXEL_BITS];
`ifdef ROWBUF_ZERO_PAD_EN
            if (32'(m_row_idx) < RB_COUNT - j) m_column[j*PIXEL_BITS +: PIXEL_BITS] = '0;
`else
`endif
        end
        m_column[RB_COUNT*PIXEL_BITS +: PIXEL_BITS] = pix_q;
    end

endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Randomized bench for row_buffer_ctrl: behavioural row memory plus a frame-level model
// of which pixel every output lane must carry.
module tb_row_buffer_ctrl;

    localparam int PB = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int KS = 3;
    localparam int RB = KS - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [PB-1:0]  s_pixel = '0;
    logic           mm_we;
    logic [PB-1:0]  mm_write_data;
    logic [2:0]     mm_write_addr;
    logic           mm_re;
    logic [1:0]     mm_read_addr;
    logic [PB*RB-1:0] mm_read_data = '0;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic [PB*KS-1:0] m_column;
    logic [1:0]     m_col_idx;
    logic [1:0]     m_row_idx;
    logic           m_full;

    row_buffer_ctrl #(
        .PIXEL_BITS  (PB),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .KERNEL_SIZE (KS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_pixel      (s_pixel),
        .mm_we        (mm_we),
        .mm_write_data(mm_write_data),
        .mm_write_addr(mm_write_addr),
        .mm_re        (mm_re),
        .mm_read_addr (mm_read_addr),
        .mm_read_data (mm_read_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_column     (m_column),
        .m_col_idx    (m_col_idx),
        .m_row_idx    (m_row_idx),
        .m_full       (m_full)
    );

    always #5 clk = ~clk;

    // Row memory: one-cycle read latency, read returns content from before the same-cycle write.
    logic [PB-1:0] mem [RB*W];
    always @(posedge clk) begin
        if (mm_re)
            for (int i = 0; i < RB; i++) mm_read_data[i*PB +: PB] <= mem[mm_read_addr*RB + i];
        if (mm_we) mem[mm_write_addr] <= mm_write_data;
    end

    typedef struct packed {
        logic [PB*KS-1:0] lanes;
        logic [KS-1:0]    known;
        logic [1:0]       col;
        logic [1:0]       row;
        logic             full;
    } exp_t;

    exp_t          q[$];
    logic [PB-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;
    int            frame = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_head();
        exp_t e;
        e = q[0];
        check_eq("m_col_idx", m_col_idx, e.col);
        check_eq("m_row_idx", m_row_idx, e.row);
        check_eq("m_full", m_full, e.full);
        for (int j = 0; j < KS; j++)
            if (e.known[j]) check_eq($sformatf("lane%0d", j), m_column[j*PB +: PB], e.lanes[j*PB +: PB]);
    endtask

    task automatic record_accept(input logic [PB-1:0] pix);
        exp_t e;
        int   src;
        // rows rotate through the slots, restarting at slot 0 each frame
        check_eq("mm_write_addr", mm_write_addr, mc * RB + (mr % RB));
        check_eq("mm_read_addr", mm_read_addr, mc);
        check_eq("mm_write_data", mm_write_data, pix);
        img[mr][mc] = pix;
        e = '0;
        e.col  = 2'(mc);
        e.row  = 2'(mr);
        e.full = (mr >= RB);
        for (int j = 0; j < RB; j++) begin
            src = mr - RB + j;
            if (src >= 0) begin
                e.known[j] = 1'b1;
                e.lanes[j*PB +: PB] = img[src][mc];
            end
`ifdef ROWBUF_ZERO_PAD_EN
            else begin
                e.known[j] = 1'b1;
                e.lanes[j*PB +: PB] = '0;
            end
`endif
        end
        e.known[RB] = 1'b1;
        e.lanes[RB*PB +: PB] = pix;
        q.push_back(e);
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) begin
                mr = 0;
                frame++;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic rdy);
        logic exp_valid;
        logic acc;
        @(negedge clk);
        s_valid = v;
        m_ready = rdy;
        s_pixel = (frame == 0) ? PB'(32'h80 + 16 * mr + mc) : PB'($urandom);
        #1;
        exp_valid = (q.size() != 0);
        acc = v && (!exp_valid || rdy);
        check_eq("m_valid", m_valid, exp_valid);
        check_eq("s_ready", s_ready, !exp_valid || rdy);
        check_eq("mm_we", mm_we, acc);
        check_eq("mm_re", mm_re, acc);
        if (exp_valid) begin
            check_head();
            if (rdy) void'(q.pop_front());
        end
        if (acc) record_accept(s_pixel);
    endtask

    initial begin
        int stall_left;
        bit stall_done;
        stall_left = 0;
        stall_done = 0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1;
        #1;
        check_eq("s_ready_pre_run", s_ready, 1'b0);

        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);

        // reset lands in the middle of row 1 while a pixel is being offered
        @(negedge clk);
        s_valid = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_s_ready", s_ready, 1'b0);
        check_eq("rst_mm_we", mm_we, 1'b0);
        check_eq("rst_m_valid", m_valid, 1'b0);
        q.delete();
        mr = 0;
        mc = 0;
        frame = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rel_s_ready", s_ready, 1'b0);
        check_eq("rel_m_full", m_full, 1'b0);
        check_eq("rel_m_row_idx", m_row_idx, 0);

        // full-rate frame with a 5-cycle stall while column (2,3) is presented
        for (int i = 0; i < 30; i++) begin
            if (!stall_done && q.size() != 0 && q[0].row == 2'd2 && q[0].col == 2'd3) begin
                stall_left = 5;
                stall_done = 1;
            end
            cycle(1'b1, stall_left == 0);
            if (stall_left > 0) stall_left--;
        end
        check_eq("stall_seen", stall_done, 1'b1);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);

        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
